lab_gate_arbiter: RTL and testbench
===================================

Name: lab_gate_arbiter

Overview:
- Shares the occupancy and door resource of the two labs (Digital, Mera) between two smart-card gate readers (A, B).
- Arbitrates reader requests round-robin and evaluates each request against the capacity and parity rules.
- Updates the per-lab student counters and sequences the door unlock pulse for a fixed number of cycles.
- Returns a per-reader acknowledge carrying accept/warning status.

Parameters:
- CAP, 30, maximum students per lab
- QUOTA, 15, count at and above which the parity rule applies
- DOOR_CYCLES, 3, cycles the door stays unlocked after an accepted transaction (must be ≥1)
- CNT_W, 6, counter width (CAP < 2**CNT_W)

Ports:
- CLK  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- reqA  in  1  reader A request, held high until ackA
- codeA  in  5  reader A smartCode
- labA  in  1  reader A target lab (0 Digital, 1 Mera)
- modeA  in  2  reader A mode (00 exit, 01 enter, 1x idle)
- ackA  out  1  one-cycle completion pulse to reader A
- reqB, codeB, labB, modeB, ackB  same as A, for reader B
- accepted  out  1  status valid with ackA/ackB: transaction performed
- warn  out  1  status valid with ackA/ackB: parity-rule rejection
- numOfStuInDigital  out  CNT_W  Digital occupancy
- numOfStuInMera  out  CNT_W  Mera occupancy
- isFullDigital, isEmptyDigital, isFullMera, isEmptyMera  out  1  registered, track counters
- unlockDigital, unlockMera  out  1  door open
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous: when rst_n=0 at an edge, the block clears all state.
  - state=IDLE; counts=0; isEmpty*=1; isFull*=0.
  - unlock*=0; ack*=0; accepted=0; warn=0; busy=0.
  - Round-robin pointer set so A wins the first tie.
- Reset asserted mid-transaction aborts the transaction: doors relock, no ack is issued, counters clear.
- FSM states: IDLE, DECIDE, OPEN, RELEASE.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the reader not granted last.
  - Latch the granted reader's code/lab/mode, then go to DECIDE.
- DECIDE (1 cycle). Evaluate using the latched lab's count C:
  - Enter (01), C==CAP: reject, warn=0.
  - Enter, C<QUOTA: accept.
  - Enter, QUOTA≤C<CAP, Digital: accept iff ^code==1, else reject with warn=1.
  - Enter, QUOTA≤C<CAP, Mera: accept iff ^code==0, else reject with warn=1.
  - Exit (00), C==0: reject, warn=0 (no underflow).
  - Exit, C>0: accept.
  - Mode 1x: reject, warn=0, no state change.
- On accept:
  - C±1 at the edge leaving DECIDE; isFull/isEmpty updated at the same edge.
  - Go to OPEN with a timer loaded to DOOR_CYCLES.
- On reject: go to RELEASE; counts unchanged.
- OPEN:
  - unlock of the latched lab is high exactly DOOR_CYCLES cycles; the other lab's unlock stays 0.
  - Then go to RELEASE.
- RELEASE (1 cycle):
  - ack of the granted reader =1; accepted/warn hold the decision.
  - Update the round-robin pointer, then go to IDLE.
- Outside RELEASE, ack*, accepted and warn are 0.
- Handshake:
  - The reader holds req and its inputs stable until it sees ack.
  - The reader deasserts req by the edge that ends the ack cycle.
  - Input changes while the reader is not granted are ignored until the grant.
- Latency from the edge that samples req in IDLE:
  - Accept: ack in cycle 3+DOOR_CYCLES.
  - Reject: ack in cycle 2.
- Only one transaction is in flight. The non-granted reader waits with req high and is served next.
- Both readers targeting the same lab are serialized, so count updates never collide.

Test Plan:
- Reset, then reqA enter Digital, code 5'b00001 → numOfStuInDigital=1, isEmptyDigital=0, unlockDigital high 3 cycles, ackA with accepted=1 at cycle 6.
- Preload Mera to 15: reqB enter Mera, code 5'b00011 (even) → count 16, accepted=1. Then code 5'b00001 (odd) → warn=1, accepted=0, count stays 16, unlockMera never high.
- Fill Digital to 30 → isFullDigital=1. Any enter → accepted=0, warn=0, count 30. Then exit → 29, isFullDigital=0.
- Exit on empty Mera → accepted=0, count stays 0, isEmptyMera=1, no unlock.
- reqA and reqB high in the same cycle → A served first, then B. Next simultaneous pair → B served first. Each ack is exactly 1 cycle.
- rst_n=0 during OPEN → next cycle: unlock*=0, counts=0, busy=0, no ack.

Source files
------------

// File: rtl/lab_gate_arbiter.sv
// Two-reader gate arbiter for the Digital and Mera labs: round-robin grant,
// capacity/parity admission check, occupancy counters and a timed door unlock.
module lab_gate_arbiter #(
  parameter int CAP         = 30,
  parameter int QUOTA       = 15,
  parameter int DOOR_CYCLES = 3,
  parameter int CNT_W       = 6
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             reqA,
  input  logic [4:0]       codeA,
  input  logic             labA,
  input  logic [1:0]       modeA,
  output logic             ackA,
  input  logic             reqB,
  input  logic [4:0]       codeB,
  input  logic             labB,
  input  logic [1:0]       modeB,
  output logic             ackB,
  output logic             accepted,
  output logic             warn,
  output logic [CNT_W-1:0] numOfStuInDigital,
  output logic [CNT_W-1:0] numOfStuInMera,
  output logic             isFullDigital,
  output logic             isEmptyDigital,
  output logic             isFullMera,
  output logic             isEmptyMera,
  output logic             unlockDigital,
  output logic             unlockMera,
  output logic             busy
);

  localparam int TMR_W = (DOOR_CYCLES < 2) ? 1 : $clog2(DOOR_CYCLES + 1);

  localparam logic [CNT_W-1:0] CAP_C   = CNT_W'(CAP);
  localparam logic [CNT_W-1:0] QUOTA_C = CNT_W'(QUOTA);
  localparam logic [TMR_W-1:0] DOOR_C  = TMR_W'(DOOR_CYCLES);

  localparam logic RD_A    = 1'b0;
  localparam logic RD_B    = 1'b1;
  localparam logic LAB_DIG = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECIDE,
    S_OPEN,
    S_RELEASE
  } state_e;

  state_e           state_q,     state_d;
  logic             grant_q,     grant_d;
  logic             last_q,      last_d;
  logic [4:0]       code_q,      code_d;
  logic             lab_q,       lab_d;
  logic [1:0]       mode_q,      mode_d;
  logic [TMR_W-1:0] timer_q,     timer_d;
  logic             accept_q,    accept_d;
  logic             warn_q,      warn_d;
  logic [CNT_W-1:0] dig_cnt_q,   dig_cnt_d;
  logic [CNT_W-1:0] mera_cnt_q,  mera_cnt_d;
  logic             full_dig_q,  full_dig_d;
  logic             empty_dig_q, empty_dig_d;
  logic             full_mera_q, full_mera_d;
  logic             empty_mera_q, empty_mera_d;

  logic [CNT_W-1:0] cur_cnt;
  logic [CNT_W-1:0] new_cnt;
  logic             dec_accept;
  logic             dec_warn;
  logic             pick_b;

  assign cur_cnt = (lab_q == LAB_DIG) ? dig_cnt_q : mera_cnt_q;
  assign new_cnt = mode_q[0] ? cur_cnt + CNT_W'(1) : cur_cnt - CNT_W'(1);

  // On a tie the reader that was not served last wins.
  assign pick_b = reqB && (!reqA || (last_q == RD_A));

  // Digital above quota needs odd code parity, Mera needs even parity.
  always_comb begin
    dec_accept = 1'b0;
    dec_warn   = 1'b0;
    case (mode_q)
      2'b01: begin
        if (cur_cnt == CAP_C) begin
          dec_accept = 1'b0;
        end else if (cur_cnt < QUOTA_C) begin
          dec_accept = 1'b1;
        end else if ((^code_q) == (lab_q == LAB_DIG)) begin
          dec_accept = 1'b1;
        end else begin
          dec_warn = 1'b1;
        end
      end
      2'b00:   dec_accept = (cur_cnt != '0);
      default: dec_accept = 1'b0;
    endcase
  end

  // NOTE: every next-state signal gets a hold default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    code_d     = code_q;
    lab_d      = lab_q;
    mode_d     = mode_q;
    timer_d    = timer_q;
    accept_d   = accept_q;
    warn_d     = warn_q;
    dig_cnt_d  = dig_cnt_q;
    mera_cnt_d = mera_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (reqA || reqB) begin
          grant_d = pick_b ? RD_B : RD_A;
          code_d  = pick_b ? codeB : codeA;
          lab_d   = pick_b ? labB  : labA;
          mode_d  = pick_b ? modeB : modeA;
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        accept_d = dec_accept;
        warn_d   = dec_warn;
        if (dec_accept) begin
          if (lab_q == LAB_DIG) dig_cnt_d  = new_cnt;
          else                  mera_cnt_d = new_cnt;
          timer_d = DOOR_C;
          state_d = S_OPEN;
        end else begin
          state_d = S_RELEASE;
        end
      end
      S_OPEN: begin
        // The door is open while the timer is non-zero; the zero cycle relocks.
        if (timer_q == '0) state_d = S_RELEASE;
        else               timer_d = timer_q - TMR_W'(1);
      end
      S_RELEASE: begin
        last_d  = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    full_dig_d   = (dig_cnt_d  == CAP_C);
    empty_dig_d  = (dig_cnt_d  == '0);
    full_mera_d  = (mera_cnt_d == CAP_C);
    empty_mera_d = (mera_cnt_d == '0);
  end

  // NOTE: reset is sampled on the clock edge and clears every register, and all
  // state uses non-blocking assignments so each register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= RD_A;
      last_q       <= RD_B;
      code_q       <= '0;
      lab_q        <= LAB_DIG;
      mode_q       <= 2'b11;
      timer_q      <= '0;
      accept_q     <= 1'b0;
      warn_q       <= 1'b0;
      dig_cnt_q    <= '0;
      mera_cnt_q   <= '0;
      full_dig_q   <= 1'b0;
      empty_dig_q  <= 1'b1;
      full_mera_q  <= 1'b0;
      empty_mera_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      code_q       <= code_d;
      lab_q        <= lab_d;
      mode_q       <= mode_d;
      timer_q      <= timer_d;
      accept_q     <= accept_d;
      warn_q       <= warn_d;
      dig_cnt_q    <= dig_cnt_d;
      mera_cnt_q   <= mera_cnt_d;
      full_dig_q   <= full_dig_d;
      empty_dig_q  <= empty_dig_d;
      full_mera_q  <= full_mera_d;
      empty_mera_q <= empty_mera_d;
    end
  end

  assign ackA     = (state_q == S_RELEASE) && (grant_q == RD_A);
  assign ackB     = (state_q == S_RELEASE) && (grant_q == RD_B);
  assign accepted = (state_q == S_RELEASE) && accept_q;
  assign warn     = (state_q == S_RELEASE) && warn_q;
  assign busy     = (state_q != S_IDLE);

  assign unlockDigital = (state_q == S_OPEN) && (timer_q != '0) && (lab_q == LAB_DIG);
  assign unlockMera    = (state_q == S_OPEN) && (timer_q != '0) && (lab_q != LAB_DIG);

  assign numOfStuInDigital = dig_cnt_q;
  assign numOfStuInMera    = mera_cnt_q;
  assign isFullDigital     = full_dig_q;
  assign isEmptyDigital    = empty_dig_q;
  assign isFullMera        = full_mera_q;
  assign isEmptyMera       = empty_mera_q;

endmodule

// File: tb/tb_lab_gate_arbiter.sv
// Bench for lab_gate_arbiter: directed scenarios plus random transactions checked
// against an occupancy model built directly from the admission rules.
module tb_lab_gate_arbiter;

  localparam int CAP   = 30;
  localparam int QUOTA = 15;
  localparam int DOOR  = 3;
  localparam int CNT_W = 6;

  logic             CLK = 1'b0;
  logic             rst_n;
  logic             reqA, reqB;
  logic [4:0]       codeA, codeB;
  logic             labA, labB;
  logic [1:0]       modeA, modeB;
  logic             ackA, ackB, accepted, warn;
  logic [CNT_W-1:0] numOfStuInDigital, numOfStuInMera;
  logic             isFullDigital, isEmptyDigital, isFullMera, isEmptyMera;
  logic             unlockDigital, unlockMera, busy;

  lab_gate_arbiter #(.CAP(CAP), .QUOTA(QUOTA), .DOOR_CYCLES(DOOR), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .reqA(reqA), .codeA(codeA), .labA(labA), .modeA(modeA), .ackA(ackA),
    .reqB(reqB), .codeB(codeB), .labB(labB), .modeB(modeB), .ackB(ackB),
    .accepted(accepted), .warn(warn),
    .numOfStuInDigital(numOfStuInDigital), .numOfStuInMera(numOfStuInMera),
    .isFullDigital(isFullDigital), .isEmptyDigital(isEmptyDigital),
    .isFullMera(isFullMera), .isEmptyMera(isEmptyMera),
    .unlockDigital(unlockDigital), .unlockMera(unlockMera), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: occupancy per lab (0 Digital, 1 Mera) and last served reader.
  int cnt [2];
  bit last_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_eval(input bit lab, input logic [4:0] code,
                                     input logic [1:0] mode, output bit acc, output bit wrn);
    int c;
    bit need_odd;
    c   = cnt[lab];
    acc = 1'b0;
    wrn = 1'b0;
    need_odd = (lab == 1'b0);
    if (mode == 2'b01) begin
      if (c >= CAP)               acc = 1'b0;
      else if (c < QUOTA)         acc = 1'b1;
      else if ((^code) == need_odd) acc = 1'b1;
      else                        wrn = 1'b1;
    end else if (mode == 2'b00) begin
      acc = (c > 0);
    end
  endfunction

  function automatic void model_commit(input bit lab, input logic [1:0] mode, input bit acc);
    if (acc) cnt[lab] = cnt[lab] + ((mode == 2'b01) ? 1 : -1);
  endfunction

  task automatic drive(input bit rd, input logic [4:0] code, input bit lab, input logic [1:0] mode);
    if (!rd) begin codeA = code; labA = lab; modeA = mode; reqA = 1'b1; end
    else     begin codeB = code; labB = lab; modeB = mode; reqB = 1'b1; end
  endtask

  task automatic drop_req(input bit rd);
    if (!rd) reqA = 1'b0;
    else     reqB = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    reqA  = 1'b0;
    reqB  = 1'b0;
    step();
    step();
    rst_n  = 1'b1;
    cnt[0] = 0;
    cnt[1] = 0;
    last_b = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_dig_cnt"}, 32'(numOfStuInDigital), 32'(cnt[0]));
    check({tag, "_mera_cnt"}, 32'(numOfStuInMera), 32'(cnt[1]));
    check({tag, "_flags"},
          32'({isFullDigital, isEmptyDigital, isFullMera, isEmptyMera}),
          32'({cnt[0] == CAP, cnt[0] == 0, cnt[1] == CAP, cnt[1] == 0}));
  endtask

  // Waits for an ack, counting cycles and door-open cycles of each lab.
  task automatic wait_ack(output int cyc, output bit who, output int ud, output int um,
                          output logic acc_o, output logic warn_o, output bit timed_out);
    cyc = 0; ud = 0; um = 0; who = 1'b0; acc_o = 1'b0; warn_o = 1'b0; timed_out = 1'b1;
    while (cyc < 40) begin
      step();
      cyc++;
      ud += int'(unlockDigital);
      um += int'(unlockMera);
      if (ackA || ackB) begin
        who = ackB; acc_o = accepted; warn_o = warn; timed_out = 1'b0;
        break;
      end
    end
  endtask

  // Serves one already-requesting reader and checks its whole transaction.
  task automatic serve(input bit rd, input logic [4:0] code, input bit lab,
                       input logic [1:0] mode, input string tag);
    bit eacc, ewrn, who, to;
    int cyc, ud, um;
    logic a, w;
    model_eval(lab, code, mode, eacc, ewrn);
    wait_ack(cyc, who, ud, um, a, w, to);
    drop_req(rd);
    check({tag, "_timeout"}, 32'(to), 32'(0));
    check({tag, "_reader"}, 32'(who), 32'(rd));
    check({tag, "_latency"}, 32'(cyc), 32'(eacc ? 3 + DOOR : 2));
    check({tag, "_accepted"}, 32'(a), 32'(eacc));
    check({tag, "_warn"}, 32'(w), 32'(ewrn));
    check({tag, "_unlock_own"}, 32'(lab ? um : ud), 32'(eacc ? DOOR : 0));
    check({tag, "_unlock_other"}, 32'(lab ? ud : um), 32'(0));
    model_commit(lab, mode, eacc);
    last_b = rd;
    check_state(tag);
  endtask

  task automatic run_txn(input bit rd, input logic [4:0] code, input bit lab,
                         input logic [1:0] mode, input string tag);
    step();
    drive(rd, code, lab, mode);
    serve(rd, code, lab, mode, tag);
  endtask

  task automatic pair_txn(input logic [4:0] ca, input bit la, input logic [1:0] ma,
                          input logic [4:0] cb, input bit lb, input logic [1:0] mb,
                          input string tag);
    bit first;
    step();
    drive(1'b0, ca, la, ma);
    drive(1'b1, cb, lb, mb);
    first = !last_b;
    if (!first) serve(1'b0, ca, la, ma, {tag, "_1st"});
    else        serve(1'b1, cb, lb, mb, {tag, "_1st"});
    step();
    check({tag, "_ack_width"}, 32'({ackA, ackB}), 32'(0));
    check({tag, "_idle_between"}, 32'(busy), 32'(0));
    if (first) serve(1'b0, ca, la, ma, {tag, "_2nd"});
    else       serve(1'b1, cb, lb, mb, {tag, "_2nd"});
  endtask

  initial begin
    logic [1:0] rmode;
    int         seen;

    rst_n = 1'b0;
    reqA = 1'b0; codeA = '0; labA = 1'b0; modeA = 2'b11;
    reqB = 1'b0; codeB = '0; labB = 1'b0; modeB = 2'b11;

    do_reset();
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_ack", 32'({ackA, ackB}), 32'(0));
    check("reset_status", 32'({accepted, warn}), 32'(0));
    check("reset_unlock", 32'({unlockDigital, unlockMera}), 32'(0));
    check_state("reset");

    run_txn(1'b0, 5'b00001, 1'b0, 2'b01, "first_enter_dig");

    for (int i = 0; i < 15; i++) run_txn(1'b1, 5'b00011, 1'b1, 2'b01, "preload_mera");
    run_txn(1'b1, 5'b00011, 1'b1, 2'b01, "mera_even_above_quota");
    run_txn(1'b1, 5'b00001, 1'b1, 2'b01, "mera_odd_warn");

    while (cnt[0] < CAP) run_txn(1'b0, 5'b00001, 1'b0, 2'b01, "fill_dig");
    run_txn(1'b1, 5'b00111, 1'b0, 2'b01, "enter_full_dig");
    run_txn(1'b0, 5'b00001, 1'b0, 2'b01, "enter_full_dig_odd");
    run_txn(1'b0, 5'b00000, 1'b0, 2'b00, "exit_full_dig");
    run_txn(1'b1, 5'b00000, 1'b0, 2'b01, "dig_even_above_quota_warn");
    run_txn(1'b0, 5'b10101, 1'b1, 2'b10, "idle_mode");

    do_reset();
    check_state("reset2");
    run_txn(1'b1, 5'b00000, 1'b1, 2'b00, "exit_empty_mera");

    pair_txn(5'b00001, 1'b0, 2'b01, 5'b00011, 1'b1, 2'b01, "pair_a_first");
    run_txn(1'b0, 5'b00001, 1'b0, 2'b01, "single_a");
    pair_txn(5'b00001, 1'b0, 2'b01, 5'b00011, 1'b0, 2'b01, "pair_b_first");

    step();
    drive(1'b0, 5'b00001, 1'b0, 2'b01);
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      step();
      if (unlockDigital) seen = 1;
    end
    check("rst_open_reached", 32'(seen), 32'(1));
    rst_n = 1'b0;
    reqA  = 1'b0;
    step();
    check("rst_open_unlock", 32'({unlockDigital, unlockMera}), 32'(0));
    check("rst_open_counts", 32'({numOfStuInDigital, numOfStuInMera}), 32'(0));
    check("rst_open_busy", 32'(busy), 32'(0));
    check("rst_open_ack", 32'({ackA, ackB}), 32'(0));
    rst_n  = 1'b1;
    cnt[0] = 0;
    cnt[1] = 0;
    last_b = 1'b1;
    step();
    check("rst_open_no_late_ack", 32'({ackA, ackB, busy}), 32'(0));
    check_state("rst_open");

    for (int i = 0; i < 120; i++) begin
      rmode = ($urandom_range(0, 3) < 2) ? 2'b01
            : ($urandom_range(0, 2) != 0) ? 2'b00 : 2'(2 + $urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0)
        pair_txn(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), rmode,
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 2'b01, "rnd_pair");
      else
        run_txn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), rmode, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
